dstream_rr_arbiter: RTL

Round-robin arbiter that shares one downstream `dstream` consumer among `NUM_IN` producing `dstream` sources. A typical consumer is the sample FIFO or the UART/packetiser that several microphone channels feed. Each grant is held for a burst of up to `BURST` beats, so a channel's samples stay contiguous. Accepted beats go to the consumer through a single registered output stage, tagged with the index of the source they came from.

---
 rtl/dstream_pkg.sv | 11 +
 rtl/rr_pick.sv | 33 +++
 rtl/dstream_rr_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/dstream_pkg.sv
// rtl/dstream_pkg.sv - shared types and helpers for the dstream round-robin arbiter
package dstream_pkg;

    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

    // Index width that stays at least 1 bit even for a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - first requester at or after ptr, wrapping modulo NUM_IN
module rr_pick
    import dstream_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int IW     = idx_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [IW-1:0]     ptr,
    output logic              found,
    output logic [IW-1:0]     idx
);

    int j;

    // Walk offsets from the far end so the smallest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NUM_IN) begin
                j = j - NUM_IN;
            end
            if (req[j]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/dstream_rr_arbiter.sv
// rtl/dstream_rr_arbiter.sv - burst round-robin arbiter from NUM_IN dstream sources to one registered output
module dstream_rr_arbiter
    import dstream_pkg::*;
#(
    parameter int N      = 16,
    parameter int NUM_IN = 4,
    parameter int BURST  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_IN-1:0]          in_ready,
    input  logic [NUM_IN*N-1:0]        in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N-1:0]               out_data,
    output logic [$clog2(NUM_IN)-1:0]  out_src
);

    localparam int IW = idx_width(NUM_IN);
    localparam int CW = $clog2(BURST + 1);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    gnt;
    logic [CW-1:0]    cnt;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic             grant_ready;
    logic             xfer;
    logic             dry;
    logic [N-1:0]     sel_data;
    logic [CW-1:0]    cnt_inc;
    logic [IW-1:0]    gnt_next;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .IW     (IW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Ready is a function of state and out_ready only, never of in_valid.
    assign grant_ready = (state == ARB_GRANT) & (~out_valid | out_ready);

    always_comb begin
        in_ready      = '0;
        in_ready[gnt] = grant_ready;
    end

    assign sel_data = in_data[int'(gnt)*N +: N];
    assign xfer     = grant_ready & in_valid[gnt];
    assign dry      = grant_ready & ~in_valid[gnt];
    assign cnt_inc  = cnt + CW'(1);
    assign gnt_next = (gnt == IW'(NUM_IN - 1)) ? '0 : gnt + IW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            gnt       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A new beat overrides the drain, so back-to-back beats flow at full rate.
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_src   <= gnt;
                cnt       <= cnt_inc;
            end
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        gnt   <= pick_idx;
                        cnt   <= '0;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if ((xfer && (cnt_inc == CW'(BURST))) || dry) begin
                        state <= ARB_IDLE;
                        ptr   <= gnt_next;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule
